// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned INIT_W = 4;

  // X31 reads as zero, so it can never carry a load result
  localparam logic [REG_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Bundle of every pipeline enable this block drives
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_freeze;
    logic id_branch_ok;
  } ctrl_t;

  localparam ctrl_t CTRL_INIT = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                  idex_flush: 1'b1, pipe_freeze: 1'b0, id_branch_ok: 1'b0};
  localparam ctrl_t CTRL_MEMWAIT = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                     idex_flush: 1'b0, pipe_freeze: 1'b1, id_branch_ok: 1'b0};
  localparam ctrl_t CTRL_EX_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                       idex_flush: 1'b1, pipe_freeze: 1'b0, id_branch_ok: 1'b0};
  localparam ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                      idex_flush: 1'b1, pipe_freeze: 1'b0, id_branch_ok: 1'b0};
  localparam ctrl_t CTRL_ID_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                       idex_flush: 1'b0, pipe_freeze: 1'b0, id_branch_ok: 1'b1};
  localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                 idex_flush: 1'b0, pipe_freeze: 1'b0, id_branch_ok: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts enabled cycles, sticks at all-ones.
//   clk, rst_n : clock, async active-low reset
//   en         : count this cycle
//   count      : current value
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, branch squashes, memory
// freeze and post-reset drain for the 5-stage core. Control outputs are
// combinational from state and inputs; counters and mem_timeout are registered.
//   clk, reset            : clock, async active-low reset
//   id_*                  : decode-stage operand/branch info
//   ex_*                  : execute-stage load/branch info
//   mem_req, dmem_ready   : data memory handshake
//   pc_en .. id_branch_ok : pipeline enables / flushes / freeze
//   mem_timeout           : sticky long-wait error
//   stall/flush/wait_count: saturating performance counters
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_reg2,
  input  logic             id_use_rs1,
  input  logic             id_use_reg2,
  input  logic             id_branch_taken,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_freeze,
  output logic             id_branch_ok,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] wait_count
);

  localparam int unsigned TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t            state, state_nxt;
  ctrl_t             ctrl;
  logic [INIT_W-1:0] init_cnt;
  logic [TW-1:0]     wait_cnt;
  logic [TW:0]       wait_inc;
  logic              memwait, loaduse, active;
  logic              stall_en, flush_en, wait_en;

  assign memwait = mem_req & ~dmem_ready;
  assign loaduse = ex_MemRead & (ex_rd != XZR) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_reg2 & (id_reg2 == ex_rd)));
  assign active  = (state != INIT);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and prioritised control outputs
  always_comb begin
    state_nxt = state;
    ctrl      = CTRL_INIT;
    stall_en  = 1'b0;
    case (state)
      INIT: begin
        if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_nxt = RUN;
      end
      RUN, MEM_WAIT: begin
        state_nxt = RUN;
        if (memwait) begin
          ctrl      = CTRL_MEMWAIT;
          state_nxt = MEM_WAIT;
        end else if (ex_branch_taken) begin
          ctrl = CTRL_EX_BRANCH;
        end else if (loaduse) begin
          ctrl     = CTRL_LOAD_USE;
          stall_en = 1'b1;
        end else if (id_branch_taken) begin
          ctrl = CTRL_ID_BRANCH;
        end else begin
          ctrl = CTRL_RUN;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign pipe_freeze  = ctrl.pipe_freeze;
  assign id_branch_ok = ctrl.id_branch_ok;

  // Post-reset drain length
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + INIT_W'(1);
    end
  end

  // Consecutive memory-wait tracking; counter parks at the limit once hit
  assign wait_inc = {1'b0, wait_cnt} + (TW + 1)'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (wait_en) begin
      if ((MEM_TIMEOUT != 0) && (wait_inc >= (TW + 1)'(MEM_TIMEOUT))) begin
        wait_cnt    <= TW'(MEM_TIMEOUT);
        mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= wait_inc[TW-1:0];
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  assign flush_en = active & ctrl.ifid_flush;
  assign wait_en  = active & memwait;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(reset), .en(stall_en), .count(stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(reset), .en(flush_en), .count(flush_count)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk(clk), .rst_n(reset), .en(wait_en), .count(wait_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: a wide-counter instance and a
// 2-bit-counter instance share stimulus and are compared against a model.
module tb_hazard_controller;

  localparam int unsigned INIT_CYCLES = 4;
  localparam int unsigned MEM_TIMEOUT = 3;
  localparam int unsigned CW          = 16;
  localparam int unsigned SW          = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_reg2, ex_rd;
  logic       id_use_rs1, id_use_reg2, id_branch_taken;
  logic       ex_MemRead, ex_branch_taken, mem_req, dmem_ready;

  logic          d_pc_en, d_ifid_en, d_ifid_flush, d_idex_flush, d_freeze, d_ok, d_to;
  logic [CW-1:0] d_stall, d_flush, d_wait;
  logic          s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush, s_freeze, s_ok, s_to;
  logic [SW-1:0] s_stall, s_flush, s_wait;

  hazard_controller #(.INIT_CYCLES(INIT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_reg2(id_reg2),
    .id_use_rs1(id_use_rs1), .id_use_reg2(id_use_reg2), .id_branch_taken(id_branch_taken),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(d_pc_en), .ifid_en(d_ifid_en), .ifid_flush(d_ifid_flush), .idex_flush(d_idex_flush),
    .pipe_freeze(d_freeze), .id_branch_ok(d_ok), .mem_timeout(d_to),
    .stall_count(d_stall), .flush_count(d_flush), .wait_count(d_wait)
  );

  hazard_controller #(.INIT_CYCLES(INIT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(SW)) u_sat (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_reg2(id_reg2),
    .id_use_rs1(id_use_rs1), .id_use_reg2(id_use_reg2), .id_branch_taken(id_branch_taken),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .pipe_freeze(s_freeze), .id_branch_ok(s_ok), .mem_timeout(s_to),
    .stall_count(s_stall), .flush_count(s_flush), .wait_count(s_wait)
  );

  always #5 clk = ~clk;

  // {pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, id_branch_ok}
  logic [11:0]     ctrl_got;
  logic [3*CW:0]   cnt_d;
  logic [3*SW:0]   cnt_s;
  assign ctrl_got = {d_pc_en, d_ifid_en, d_ifid_flush, d_idex_flush, d_freeze, d_ok,
                     s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush, s_freeze, s_ok};
  assign cnt_d    = {d_stall, d_flush, d_wait, d_to};
  assign cnt_s    = {s_stall, s_flush, s_wait, s_to};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_init_left, m_run, m_stall, m_flush, m_wait;
  bit m_to;

  task automatic model_reset();
    m_init_left = INIT_CYCLES;
    m_run = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
  endtask

  // Expected control vector from the priority rules
  function automatic logic [5:0] exp_ctrl();
    logic lu;
    if (!reset || m_init_left > 0) return 6'b001100;
    if (mem_req && !dmem_ready) return 6'b000010;
    if (ex_branch_taken) return 6'b111100;
    lu = ex_MemRead && (ex_rd != 5'd31) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_reg2 && id_reg2 == ex_rd));
    if (lu) return 6'b000100;
    if (id_branch_taken) return 6'b111001;
    return 6'b110000;
  endfunction

  function automatic logic [SW-1:0] sat(input int v);
    return (v > 3) ? SW'(3) : SW'(v);
  endfunction

  function automatic logic [3*CW:0] exp_cnt_d();
    return {CW'(m_stall), CW'(m_flush), CW'(m_wait), m_to};
  endfunction

  function automatic logic [3*SW:0] exp_cnt_s();
    return {sat(m_stall), sat(m_flush), sat(m_wait), m_to};
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    logic [5:0] e;
    if (!reset) begin model_reset(); return; end
    if (m_init_left > 0) begin m_init_left--; return; end
    e = exp_ctrl();
    if (e == 6'b000010) begin
      m_wait++; m_run++;
      if (m_run >= int'(MEM_TIMEOUT)) m_to = 1;
    end else begin
      m_run = 0;
    end
    if (e[3]) m_flush++;
    if (e == 6'b000100) m_stall++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] r2, input logic u1,
                       input logic u2, input logic idb, input logic [4:0] rd, input logic mr,
                       input logic exb, input logic mq, input logic rdy);
    id_rs1 = rs1; id_reg2 = r2; id_use_rs1 = u1; id_use_reg2 = u2; id_branch_taken = idb;
    ex_rd = rd; ex_MemRead = mr; ex_branch_taken = exb; mem_req = mq; dmem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rand_inputs();
    drive(5'($urandom_range(29, 31)), 5'($urandom_range(29, 31)), 1'($urandom),
          1'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom_range(29, 31)),
          1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
          1'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    idle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ctrl_got !== {2{6'b001100}}) $display("FAIL reset_ctrl got %b exp %b", ctrl_got, {2{6'b001100}});
      else n_pass++;
      cycle();
    end
    n_checks++;
    if ({cnt_d, cnt_s} !== '0) $display("FAIL reset_counters got %h exp 0", {cnt_d, cnt_s});
    else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < int'(INIT_CYCLES); i++) begin
      rand_inputs();
      #1;
      n_checks++;
      if (ctrl_got !== {2{6'b001100}}) $display("FAIL init_drain[%0d] got %b exp %b", i, ctrl_got, {2{6'b001100}});
      else n_pass++;
      cycle();
    end
    idle();
    #1;
    n_checks++;
    if (ctrl_got !== {2{6'b110000}}) $display("FAIL init_exit got %b exp %b", ctrl_got, {2{6'b110000}});
    else n_pass++;
    n_checks++;
    if ({cnt_d, cnt_s} !== '0) $display("FAIL init_counters got %h exp 0", {cnt_d, cnt_s});
    else n_pass++;
  endtask

  task automatic test_load_use();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (ctrl_got !== {2{6'b000100}}) $display("FAIL lu_rs1 got %b exp %b", ctrl_got, {2{6'b000100}});
    else n_pass++;
    cycle();
    idle();
    #1;
    n_checks++;
    if (d_stall !== CW'(1) || s_stall !== SW'(1)) $display("FAIL lu_count got %0d/%0d exp 1", d_stall, s_stall);
    else n_pass++;
    drive(5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (ctrl_got !== {2{6'b110000}}) $display("FAIL lu_xzr got %b exp %b", ctrl_got, {2{6'b110000}});
    else n_pass++;
    cycle();
    drive(5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (ctrl_got !== {2{6'b000100}}) $display("FAIL lu_reg2 got %b exp %b", ctrl_got, {2{6'b000100}});
    else n_pass++;
    cycle();
    drive(5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (ctrl_got !== {2{6'b110000}}) $display("FAIL lu_reg2_unused got %b exp %b", ctrl_got, {2{6'b110000}});
    else n_pass++;
    cycle();
    n_checks++;
    if (cnt_d !== exp_cnt_d() || d_stall !== CW'(2)) $display("FAIL lu_counters got %h exp %h", cnt_d, exp_cnt_d());
    else n_pass++;
  endtask

  task automatic test_branch_prec();
    int f0;
    f0 = m_flush;
    drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (ctrl_got !== {2{6'b111100}}) $display("FAIL ex_branch_prec got %b exp %b", ctrl_got, {2{6'b111100}});
    else n_pass++;
    cycle();
    idle();
    #1;
    n_checks++;
    if (d_flush !== CW'(f0 + 1) || cnt_d !== exp_cnt_d()) $display("FAIL ex_branch_count got %h exp %h", cnt_d, exp_cnt_d());
    else n_pass++;
  endtask

  task automatic test_id_branch();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (ctrl_got !== {2{6'b111001}}) $display("FAIL id_branch got %b exp %b", ctrl_got, {2{6'b111001}});
    else n_pass++;
    cycle();
    idle();
    #1;
    n_checks++;
    if (cnt_d !== exp_cnt_d() || cnt_s !== exp_cnt_s()) $display("FAIL id_branch_count got %h exp %h", cnt_d, exp_cnt_d());
    else n_pass++;
  endtask

  task automatic test_mem_wait();
    drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      #1;
      n_checks++;
      if (ctrl_got !== {2{6'b000010}}) $display("FAIL mem_freeze[%0d] got %b exp %b", i, ctrl_got, {2{6'b000010}});
      else n_pass++;
      cycle();
      n_checks++;
      if (d_to !== (i >= 3) || s_to !== (i >= 3)) $display("FAIL mem_timeout[%0d] got %b exp %b", i, d_to, (i >= 3));
      else n_pass++;
    end
    n_checks++;
    if (d_wait !== CW'(5) || s_wait !== SW'(3)) $display("FAIL wait_count got %0d/%0d exp 5/3", d_wait, s_wait);
    else n_pass++;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (ctrl_got !== {2{6'b111001}}) $display("FAIL mem_release got %b exp %b", ctrl_got, {2{6'b111001}});
    else n_pass++;
    cycle();
    idle();
    #1;
    n_checks++;
    if (cnt_d !== exp_cnt_d() || cnt_s !== exp_cnt_s()) $display("FAIL mem_release_count got %h exp %h", cnt_d, exp_cnt_d());
    else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive(5'd0, 5'(i + 1), 1'b0, 1'b1, 1'b0, 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if (ctrl_got !== {2{6'b000100}}) $display("FAIL sat_stall[%0d] got %b exp %b", i, ctrl_got, {2{6'b000100}});
      else n_pass++;
      cycle();
    end
    idle();
    #1;
    n_checks++;
    if (s_stall !== SW'(3) || d_stall !== CW'(m_stall)) $display("FAIL sat_count got %0d/%0d exp 3/%0d", s_stall, d_stall, m_stall);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      #1;
      n_checks++;
      if (ctrl_got !== {2{exp_ctrl()}}) $display("FAIL rand_ctrl[%0d] got %b exp %b", i, ctrl_got, {2{exp_ctrl()}});
      else n_pass++;
      cycle();
      n_checks++;
      if (cnt_d !== exp_cnt_d() || cnt_s !== exp_cnt_s())
        $display("FAIL rand_cnt[%0d] got %h/%h exp %h/%h", i, cnt_d, cnt_s, exp_cnt_d(), exp_cnt_s());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_wait();
    idle();
    cycle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) cycle();
    n_checks++;
    if (d_to !== 1'b1) $display("FAIL pre_reset_timeout got %b exp 1", d_to);
    else n_pass++;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (ctrl_got !== {2{6'b001100}}) $display("FAIL async_reset_ctrl got %b exp %b", ctrl_got, {2{6'b001100}});
    else n_pass++;
    n_checks++;
    if ({cnt_d, cnt_s} !== '0) $display("FAIL async_reset_state got %h exp 0", {cnt_d, cnt_s});
    else n_pass++;
    cycle();
    reset = 1'b1;
    for (int i = 0; i < int'(INIT_CYCLES); i++) begin
      #1;
      n_checks++;
      if (ctrl_got !== {2{6'b001100}}) $display("FAIL redrain[%0d] got %b exp %b", i, ctrl_got, {2{6'b001100}});
      else n_pass++;
      cycle();
    end
    idle();
    #1;
    n_checks++;
    if (ctrl_got !== {2{6'b110000}} || cnt_d !== '0) $display("FAIL redrain_exit got %b %h exp %b 0", ctrl_got, cnt_d, {2{6'b110000}});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_prec();
    test_id_branch();
    test_mem_wait();
    test_saturation();
    test_random();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
